cnn_img_streamer: RTL and testbench
===================================

Name: cnn_img_streamer

Overview:
- Synthesizable on-chip image sequencer and scorer for the CNN MNIST core.
- Reads NUM images of IMG_W×IMG_H pixels from an external pixel ROM and streams each into the CNN core with a pixel-valid strobe. Resets the core between images, compares each decision against a label ROM, and reports hit count and integer accuracy percent.
- Generalises the existing bench flow with parametric image geometry, runtime image count, sequential or strided image order, per-image timeout, and hardware accuracy computation.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- PIX_W, 8, pixel width
- CNT_W, 11, width of image index and counters (max 2^CNT_W−1 images)
- ADDR_W, 20, pixel ROM address width
- RST_CYC, 2, cycles cnn_rst_n is held low before each image
- TIMEOUT, 4096, max cycles to wait for cnn_valid_out after the last pixel

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- num_img  in  CNT_W  images per run, sampled on start
- stride_mode  in  1  0 = sequential order, 1 = strided order; sampled on start
- stride  in  CNT_W  index step in strided mode (must be <num_img); sampled on start
- mem_rd_en  out  1  pixel ROM read strobe
- mem_addr  out  ADDR_W  pixel ROM address = idx·P + k, with P = IMG_W·IMG_H
- mem_rdata  in  PIX_W  ROM data; valid 1 cycle after mem_rd_en
- lbl_addr  out  CNT_W  label ROM address = current idx
- lbl_rdata  in  4  label; valid 1 cycle after lbl_addr changes
- cnn_rst_n  out  1  reset to the CNN core
- cnn_pix_valid  out  1  pixel strobe to the core
- cnn_data_in  out  PIX_W  pixel to the core
- cnn_valid_out  in  1  core decision valid
- cnn_decision  in  4  core decision
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- img_cnt  out  CNT_W  images scored
- hit_cnt  out  CNT_W  correct decisions
- timeout_cnt  out  CNT_W  images that timed out (scored as miss)
- acc_pct  out  7  floor(100·hit_cnt/num_img); valid from done onward

Behaviour:
- Reset: all outputs 0; cnn_rst_n=0; FSM=IDLE. Reset in any state aborts the run immediately, without asserting done.
- All outputs are registered.
- IDLE:
  - cnn_rst_n=1.
  - On start: latch inputs; clear idx, img_cnt, hit_cnt, timeout_cnt and acc_pct; set busy=1.
  - If num_img==0: go to CALC (acc_pct=0).
  - Otherwise go to CRST.
  - start outside IDLE is ignored.
- CRST: cnn_rst_n=0 for exactly RST_CYC cycles; lbl_addr=idx; then STREAM.
- STREAM:
  - Issue P consecutive reads, k=0..P−1, one per cycle, mem_rd_en=1.
  - Pixel k appears on cnn_data_in with cnn_pix_valid=1 exactly 2 cycles after its read. The P valid cycles are contiguous.
  - cnn_pix_valid=0 and cnn_data_in holds its last value otherwise.
  - Latch lbl_rdata during STREAM.
  - After the last pixel's valid cycle, go to WAIT.
- WAIT:
  - On cnn_valid_out=1: hit if cnn_decision==label; hit_cnt+=hit; img_cnt+=1; go to NEXT.
  - If TIMEOUT cycles elapse with no cnn_valid_out: timeout_cnt+=1; img_cnt+=1; miss; go to NEXT.
  - cnn_valid_out in any other state is ignored.
- NEXT:
  - If img_cnt==num_img: go to CALC.
  - Otherwise advance idx and go to CRST:
    - sequential: idx+1
    - strided: idx+stride; subtract num_img if the result is ≥num_img, using CNT_W+1-bit arithmetic.
- CALC:
  - Compute acc_pct by restoring subtraction: quotient of hit_cnt·100 / num_img, ≤ CNT_W+7 cycles.
  - Then set done=1 for 1 cycle, busy=0, and go to IDLE.
  - Counters and acc_pct hold until the next start.
- Simultaneous events:
  - cnn_valid_out in the same cycle the timeout expires counts as a valid decision, not a timeout.
  - start in the same cycle as done is ignored.
- hit_cnt ≤ img_cnt ≤ num_img at all times.
- Counters never wrap within a run.

Test Plan (IMG_W=IMG_H=4, P=16, RST_CYC=2, TIMEOUT=32; ROM pixel = address[7:0]):
- num_img=3, sequential; core model answers the label 5 cycles after the last pixel:
  - mem_addr runs 0..15, 16..31, 32..47, each preceded by 2 cycles of cnn_rst_n=0.
  - cnn_data_in sequence matches the addresses, 2 cycles after each read.
  - hit_cnt=3, acc_pct=100, one done pulse.
- num_img=4, stride_mode=1, stride=3:
  - idx order 0,3,2,1 (lbl_addr shows the same).
  - Core wrong on idx 2: hit_cnt=3, acc_pct=75.
- num_img=2; core never asserts cnn_valid_out:
  - Each image waits exactly 32 cycles.
  - timeout_cnt=2, hit_cnt=0, acc_pct=0, done asserted.
- num_img=0 → done within CNT_W+8 cycles; all counters 0; no mem_rd_en.
- rst_n low during STREAM of image 1 → next cycle busy=0, mem_rd_en=0, cnn_rst_n=0, counters 0, no done. A fresh start then completes normally.
- Protocol edge cases:
  - start pulsed during WAIT → ignored.
  - cnn_valid_out pulsed during STREAM → not scored.
  - cnn_valid_out on the 32nd wait cycle → scored as a decision; timeout_cnt unchanged.

Source files
------------

// File: rtl/cnn_img_streamer.sv
// Image sequencer and scorer for the CNN MNIST core: streams images from a pixel ROM,
// scores each decision against a label ROM and computes integer accuracy.
//
// state  | meaning
// IDLE   | waiting for start; core out of reset
// CRST   | holding the core in reset before an image
// STREAM | issuing pixel reads and draining the 2-cycle pixel pipeline
// WAIT   | waiting for the core decision or timeout
// NEXT   | deciding between next image and accuracy computation
// CALC   | restoring division for acc_pct, then done
module cnn_img_streamer #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int PIX_W   = 8,
  parameter int CNT_W   = 11,
  parameter int ADDR_W  = 20,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_img,
  input  logic              stride_mode,
  input  logic [CNT_W-1:0]  stride,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [CNT_W-1:0]  lbl_addr,
  input  logic [3:0]        lbl_rdata,
  output logic              cnn_rst_n,
  output logic              cnn_pix_valid,
  output logic [PIX_W-1:0]  cnn_data_in,
  input  logic              cnn_valid_out,
  input  logic [3:0]        cnn_decision,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  img_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic [6:0]        acc_pct
);

  localparam int P    = IMG_W * IMG_H;
  localparam int KW   = $clog2(P + 2);
  localparam int TMAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = CNT_W + 7;
  localparam int DCW  = $clog2(DW + 1);

  localparam logic [KW-1:0]    K_LAST_RD = KW'(P - 1);
  localparam logic [KW-1:0]    K_END     = KW'(P + 1);
  localparam logic [TW-1:0]    T_RST     = TW'(RST_CYC - 1);
  localparam logic [TW-1:0]    T_WAIT    = TW'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   ONE_W     = (CNT_W+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_STREAM, S_WAIT, S_NEXT, S_CALC} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   idx, idx_nxt, num_q, num_nxt, stride_q, stride_nxt;
  logic               smode_q, smode_nxt;
  logic [KW-1:0]      k, k_nxt;
  logic [TW-1:0]      tmr, tmr_nxt;
  logic [3:0]         label_q, label_nxt;
  logic [DW-1:0]      dvd, dvd_nxt;
  logic [CNT_W-1:0]   rem, rem_nxt;
  logic [DCW-1:0]     div_cnt, div_cnt_nxt;

  logic               mem_rd_en_nxt, cnn_rst_n_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [CNT_W-1:0]   lbl_addr_nxt, img_cnt_nxt, hit_cnt_nxt, timeout_cnt_nxt;
  logic [6:0]         acc_pct_nxt;
  logic               rd_d1;

  logic [ADDR_W-1:0]  base;
  logic [CNT_W:0]     step, idx_sum, rem_sh;
  logic [CNT_W-1:0]   idx_adv;
  logic               ge;

  always_comb begin
    base    = ADDR_W'(idx) * ADDR_W'(P);
    step    = smode_q ? {1'b0, stride_q} : ONE_W;
    idx_sum = {1'b0, idx} + step;
    // Strided wrap uses one extra bit so idx+stride cannot overflow before the compare.
    idx_adv = (smode_q && (idx_sum >= {1'b0, num_q})) ? CNT_W'(idx_sum - {1'b0, num_q})
                                                      : idx_sum[CNT_W-1:0];
    rem_sh  = {rem, dvd[DW-1]};
    ge      = rem_sh >= {1'b0, num_q};
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    num_nxt         = num_q;
    stride_nxt      = stride_q;
    smode_nxt       = smode_q;
    k_nxt           = k;
    tmr_nxt         = tmr;
    label_nxt       = label_q;
    dvd_nxt         = dvd;
    rem_nxt         = rem;
    div_cnt_nxt     = div_cnt;
    mem_rd_en_nxt   = mem_rd_en;
    mem_addr_nxt    = mem_addr;
    lbl_addr_nxt    = lbl_addr;
    cnn_rst_n_nxt   = cnn_rst_n;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    img_cnt_nxt     = img_cnt;
    hit_cnt_nxt     = hit_cnt;
    timeout_cnt_nxt = timeout_cnt;
    acc_pct_nxt     = acc_pct;

    case (state)
      S_IDLE: begin
        cnn_rst_n_nxt = 1'b1;
        // done is high in the first IDLE cycle; a start there is dropped.
        if (start && !done) begin
          num_nxt         = num_img;
          smode_nxt       = stride_mode;
          stride_nxt      = stride;
          idx_nxt         = '0;
          img_cnt_nxt     = '0;
          hit_cnt_nxt     = '0;
          timeout_cnt_nxt = '0;
          acc_pct_nxt     = '0;
          busy_nxt        = 1'b1;
          if (num_img == '0) begin
            state_nxt = S_CALC;
          end else begin
            state_nxt     = S_CRST;
            cnn_rst_n_nxt = 1'b0;
            lbl_addr_nxt  = '0;
            tmr_nxt       = T_RST;
          end
        end
      end
      S_CRST: begin
        if (tmr == '0) begin
          state_nxt     = S_STREAM;
          cnn_rst_n_nxt = 1'b1;
          mem_rd_en_nxt = 1'b1;
          mem_addr_nxt  = base;
          k_nxt         = '0;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      S_STREAM: begin
        label_nxt = lbl_rdata;
        k_nxt     = k + KW'(1);
        if (k < K_LAST_RD) mem_addr_nxt = mem_addr + ADDR_W'(1);
        else               mem_rd_en_nxt = 1'b0;
        if (k == K_END) begin
          state_nxt = S_WAIT;
          tmr_nxt   = T_WAIT;
        end
      end
      S_WAIT: begin
        if (cnn_valid_out) begin
          img_cnt_nxt = img_cnt + CNT_W'(1);
          if (cnn_decision == label_q) hit_cnt_nxt = hit_cnt + CNT_W'(1);
          state_nxt = S_NEXT;
        end else if (tmr == '0) begin
          img_cnt_nxt     = img_cnt + CNT_W'(1);
          timeout_cnt_nxt = timeout_cnt + CNT_W'(1);
          state_nxt       = S_NEXT;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      S_NEXT: begin
        if (img_cnt == num_q) begin
          state_nxt   = S_CALC;
          dvd_nxt     = DW'(hit_cnt) * DW'(100);
          rem_nxt     = '0;
          div_cnt_nxt = DCW'(DW);
        end else begin
          state_nxt     = S_CRST;
          idx_nxt       = idx_adv;
          lbl_addr_nxt  = idx_adv;
          cnn_rst_n_nxt = 1'b0;
          tmr_nxt       = T_RST;
        end
      end
      S_CALC: begin
        if (num_q == '0) begin
          acc_pct_nxt = '0;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = S_IDLE;
        end else begin
          // Quotient bits shift into the dividend register as it empties.
          dvd_nxt     = {dvd[DW-2:0], ge};
          rem_nxt     = ge ? CNT_W'(rem_sh - {1'b0, num_q}) : rem_sh[CNT_W-1:0];
          div_cnt_nxt = div_cnt - DCW'(1);
          if (div_cnt == DCW'(1)) begin
            acc_pct_nxt = {dvd[5:0], ge};
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
            state_nxt   = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      num_q       <= '0;
      stride_q    <= '0;
      smode_q     <= 1'b0;
      k           <= '0;
      tmr         <= '0;
      label_q     <= '0;
      dvd         <= '0;
      rem         <= '0;
      div_cnt     <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      lbl_addr    <= '0;
      cnn_rst_n   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      img_cnt     <= '0;
      hit_cnt     <= '0;
      timeout_cnt <= '0;
      acc_pct     <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      num_q       <= num_nxt;
      stride_q    <= stride_nxt;
      smode_q     <= smode_nxt;
      k           <= k_nxt;
      tmr         <= tmr_nxt;
      label_q     <= label_nxt;
      dvd         <= dvd_nxt;
      rem         <= rem_nxt;
      div_cnt     <= div_cnt_nxt;
      mem_rd_en   <= mem_rd_en_nxt;
      mem_addr    <= mem_addr_nxt;
      lbl_addr    <= lbl_addr_nxt;
      cnn_rst_n   <= cnn_rst_n_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      img_cnt     <= img_cnt_nxt;
      hit_cnt     <= hit_cnt_nxt;
      timeout_cnt <= timeout_cnt_nxt;
      acc_pct     <= acc_pct_nxt;
    end
  end

  // ROM data lands one cycle after the read; one more register puts it on the core.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_d1         <= 1'b0;
      cnn_pix_valid <= 1'b0;
      cnn_data_in   <= '0;
    end else begin
      rd_d1         <= mem_rd_en;
      cnn_pix_valid <= rd_d1;
      if (rd_d1) cnn_data_in <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cnn_img_streamer.sv
// Bench for cnn_img_streamer with 4x4 images: scoreboarded reads/pixels/labels,
// behavioural CNN core, and directed runs covering ordering, timeouts and reset abort.
module tb_cnn_img_streamer;
  localparam int CNT_W = 11;
  localparam int ADDR_W = 20;
  localparam int PIX_W = 8;
  localparam int P = 16;
  localparam int TO = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stride_mode = 1'b0;
  logic [CNT_W-1:0] num_img = '0, stride = '0;
  logic mem_rd_en, cnn_rst_n, cnn_pix_valid, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0] mem_rdata = '0, cnn_data_in;
  logic [CNT_W-1:0] lbl_addr, img_cnt, hit_cnt, timeout_cnt;
  logic [3:0] lbl_rdata = '0, cnn_decision = '0;
  logic cnn_valid_out = 1'b0;
  logic [6:0] acc_pct;

  int checks = 0, errors = 0, cyc = 0, done_seen = 0;
  int exp_addr[$], exp_pix[$], exp_lbl[$];
  int core_delay = 5, core_wrong = -1, exp_gap = 6;
  bit core_never = 1'b0, inj_stream = 1'b0, inj_wait = 1'b0, inj_done = 1'b0;
  int exp_hits, exp_tos, d0;

  cnn_img_streamer #(.IMG_W(4), .IMG_H(4), .PIX_W(PIX_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
                     .RST_CYC(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_img(num_img), .stride_mode(stride_mode),
    .stride(stride), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .lbl_addr(lbl_addr), .lbl_rdata(lbl_rdata), .cnn_rst_n(cnn_rst_n),
    .cnn_pix_valid(cnn_pix_valid), .cnn_data_in(cnn_data_in), .cnn_valid_out(cnn_valid_out),
    .cnn_decision(cnn_decision), .busy(busy), .done(done), .img_cnt(img_cnt),
    .hit_cnt(hit_cnt), .timeout_cnt(timeout_cnt), .acc_pct(acc_pct));

  always #5 clk = ~clk;

  function automatic logic [3:0] lbl_of(input int i);
    return 4'((i * 7 + 3) % 10);
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_addr[7:0];
    lbl_rdata <= lbl_of(int'(lbl_addr));
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Build the expected read/pixel/label stream and score for one run.
  task automatic setup(input int n, input bit sm, input int st, input int dly,
                       input bit never, input int wrong);
    int i;
    exp_addr.delete(); exp_pix.delete(); exp_lbl.delete();
    i = 0; exp_hits = 0; exp_tos = 0;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < P; k++) begin
        exp_addr.push_back(i * P + k);
        exp_pix.push_back((i * P + k) & 255);
      end
      exp_lbl.push_back(i);
      if (never) exp_tos++;
      else if (i != wrong) exp_hits++;
      i = sm ? (i + st) % n : i + 1;
    end
    core_delay = dly; core_never = never; core_wrong = wrong;
    exp_gap = never ? TO + 1 : dly + 1;
  endtask

  task automatic kick(input int n, input bit sm, input int st);
    d0 = done_seen;
    num_img = CNT_W'(n); stride_mode = sm; stride = CNT_W'(st);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int n, input bit sm, input int st, input int dly,
                     input bit never, input int wrong, input int lat_max);
    int t;
    setup(n, sm, st, dly, never, wrong);
    kick(n, sm, st);
    t = 0;
    while (t < n * 80 + 60 && done_seen == d0) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_reached"}, done_seen != d0, 1);
    if (lat_max > 0) check({tag, "_latency_ok"}, t <= lat_max, 1);
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, done_seen - d0, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_img_cnt"}, img_cnt, n);
    check({tag, "_hit_cnt"}, hit_cnt, exp_hits);
    check({tag, "_timeout_cnt"}, timeout_cnt, exp_tos);
    check({tag, "_acc_pct"}, acc_pct, (n == 0) ? 0 : (exp_hits * 100) / n);
    check({tag, "_reads_left"}, exp_addr.size(), 0);
    check({tag, "_pix_left"}, exp_pix.size(), 0);
  endtask

  initial begin
    fork
      begin : mon
        int pcount, cd, low_cnt, last_pix, prev_img, x;
        bit my_start;
        pcount = 0; cd = 0; low_cnt = 0; last_pix = 0; prev_img = 0; my_start = 1'b0;
        forever begin
          @(negedge clk);
          cyc++;
          if (my_start) begin start = 1'b0; my_start = 1'b0; end
          cnn_valid_out = 1'b0;
          if (done) begin
            done_seen++;
            if (inj_done) begin start = 1'b1; my_start = 1'b1; inj_done = 1'b0; end
          end
          if (mem_rd_en) begin
            if (exp_addr.size() == 0) check("rd_unexpected", mem_addr, -1);
            else check("mem_addr", mem_addr, exp_addr.pop_front());
            if (mem_addr[3:0] == 4'd0) begin
              if (exp_lbl.size() == 0) check("lbl_unexpected", lbl_addr, -1);
              else check("lbl_addr", lbl_addr, exp_lbl.pop_front());
            end
          end
          if (cnn_pix_valid) begin
            if (exp_pix.size() == 0) check("pix_unexpected", cnn_data_in, -1);
            else check("cnn_data_in", cnn_data_in, exp_pix.pop_front());
            last_pix = cyc;
          end
          if (!rst_n) low_cnt = 0;
          else if (busy && !cnn_rst_n) low_cnt++;
          else if (cnn_rst_n && low_cnt > 0) begin
            check("crst_len", low_cnt, 2);
            low_cnt = 0;
          end
          if (busy && int'(img_cnt) == prev_img + 1) check("wait_gap", cyc - last_pix, exp_gap);
          prev_img = int'(img_cnt);
          if (cd > 0) begin
            cd--;
            if (cd == 0) begin
              cnn_valid_out = 1'b1;
              x = int'(lbl_of(int'(lbl_addr)));
              if (int'(lbl_addr) == core_wrong) x = (x + 1) % 10;
              cnn_decision = 4'(x);
            end
          end
          if (inj_wait && cd == 2) begin start = 1'b1; my_start = 1'b1; inj_wait = 1'b0; end
          if (!cnn_rst_n) pcount = 0;
          else if (cnn_pix_valid) begin
            pcount++;
            if (inj_stream && pcount == 8) begin
              cnn_valid_out = 1'b1;
              cnn_decision = lbl_of(int'(lbl_addr));
              inj_stream = 1'b0;
            end
            if (pcount == P && !core_never) cd = core_delay;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_cnn_rst_n", cnn_rst_n, 0);
    check("rst_pix_valid", cnn_pix_valid, 0);
    check("rst_img_cnt", img_cnt, 0);
    check("rst_acc_pct", acc_pct, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cnn_rst_n", cnn_rst_n, 1);

    inj_wait = 1'b1;
    run("seq3", 3, 1'b0, 0, 5, 1'b0, -1, 0);
    inj_stream = 1'b1;
    run("stride4", 4, 1'b1, 3, 5, 1'b0, 2, 0);
    run("stride3", 3, 1'b1, 2, 5, 1'b0, 1, 0);
    run("timeout2", 2, 1'b0, 0, 5, 1'b1, -1, 0);
    inj_done = 1'b1;
    run("zero", 0, 1'b0, 0, 5, 1'b0, -1, CNT_W + 8);
    run("edge32", 1, 1'b0, 0, TO, 1'b0, -1, 0);

    setup(3, 1'b0, 0, 5, 1'b0, -1);
    kick(3, 1'b0, 0);
    for (int t = 0; t < 500 && !(mem_rd_en && mem_addr == 20); t++) @(negedge clk);
    check("abort_reached_img1", mem_rd_en && mem_addr == 20, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_mem_rd_en", mem_rd_en, 0);
    check("abort_cnn_rst_n", cnn_rst_n, 0);
    check("abort_img_cnt", img_cnt, 0);
    check("abort_hit_cnt", hit_cnt, 0);
    rst_n = 1'b1;
    exp_addr.delete(); exp_pix.delete(); exp_lbl.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", done_seen - d0, 0);
    run("after_abort", 3, 1'b0, 0, 5, 1'b0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
